// File: rtl/fp16_divider.sv
// Iterative IEEE-754 binary16 divider (out = A / B), restoring mantissa division, flush-to-zero.
// Define FP16_DIV_RNE_EN for round-to-nearest-even; the default build rounds toward zero.
module fp16_divider #(
    parameter int unsigned ITERS_PER_CYCLE = 1,
    parameter logic [15:0] CANON_NAN       = 16'h7E00
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] out,
    output logic        dz,
    output logic        inv
);

    localparam int unsigned QW         = 14;
    localparam int unsigned MW         = 11;
    localparam int unsigned RW         = 12;
    localparam int unsigned DIV_CYCLES = QW / ITERS_PER_CYCLE;
    localparam int unsigned CW         = $clog2(DIV_CYCLES + 1);

    if ((QW % ITERS_PER_CYCLE) != 0) begin : g_bad_iters
        $error("ITERS_PER_CYCLE must divide 14");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DIV,
        S_NORM,
        S_DONE
    } state_t;

    state_t          state;
    logic [15:0]     a_r;
    logic [15:0]     b_r;
    logic [RW-1:0]   rem_r;
    logic [MW-1:0]   mb_r;
    logic [QW-1:0]   q_r;
    logic [CW-1:0]   cnt;

    // Operand unpack; exponent 0 is treated as zero (subnormals flushed)
    logic       sgn;
    logic [4:0] ea, eb;
    logic [9:0] fa, fb;
    logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sgn    = a_r[15] ^ b_r[15];
    assign ea     = a_r[14:10];
    assign eb     = b_r[14:10];
    assign fa     = a_r[9:0];
    assign fb     = b_r[9:0];
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign a_zero = ~(|ea);
    assign b_zero = ~(|eb);

    // Special-case result, in priority order
    logic        spec;
    logic [15:0] sp_out;
    logic        sp_dz;
    logic        sp_inv;

    always_comb begin
        spec   = 1'b1;
        sp_out = 16'h0000;
        sp_dz  = 1'b0;
        sp_inv = 1'b0;
        if (a_nan | b_nan) begin
            sp_out = CANON_NAN;
            sp_inv = 1'b1;
        end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
            sp_out = CANON_NAN;
            sp_inv = 1'b1;
        end else if (a_inf) begin
            sp_out = {sgn, 5'h1F, 10'h000};
        end else if (b_zero) begin
            sp_out = {sgn, 5'h1F, 10'h000};
            sp_dz  = 1'b1;
        end else if (b_inf | a_zero) begin
            sp_out = {sgn, 15'h0000};
        end else begin
            spec = 1'b0;
        end
    end

    // ITERS_PER_CYCLE restoring steps per DIV cycle
    logic [RW-1:0] r_nx;
    logic [QW-1:0] q_nx;

    always_comb begin
        r_nx = rem_r;
        q_nx = q_r;
        for (int unsigned i = 0; i < ITERS_PER_CYCLE; i++) begin
            if (r_nx >= {1'b0, mb_r}) begin
                q_nx = {q_nx[QW-2:0], 1'b1};
                r_nx = r_nx - {1'b0, mb_r};
            end else begin
                q_nx = {q_nx[QW-2:0], 1'b0};
            end
            r_nx = {r_nx[RW-2:0], 1'b0};
        end
    end

    // Normalise, round and pack; q_r[13] carries weight 2^0
    logic        q_hi;
    logic [9:0]  frac;
    logic        inc;
    logic [10:0] frac_sum;
    logic [6:0]  e_n;
    logic [6:0]  e_f;
    logic [15:0] norm_out;

`ifdef FP16_DIV_RNE_EN
    logic guard;
    logic sticky;
    assign guard  = q_hi ? q_r[2] : q_r[1];
    assign sticky = (q_hi ? (|q_r[1:0]) : q_r[0]) | (|rem_r);
    assign inc    = guard & (sticky | frac[0]);
`else
    assign inc    = 1'b0;
`endif

    always_comb begin
        q_hi     = q_r[QW-1];
        frac     = q_hi ? q_r[12:3] : q_r[11:2];
        frac_sum = {1'b0, frac} + 11'(inc);
        e_n      = 7'({2'b00, ea}) + 7'd15 - 7'({2'b00, eb}) - 7'({6'b000000, ~q_hi});
        e_f      = e_n + 7'({6'b000000, frac_sum[10]});
        if ($signed(e_f) >= 7'sd31) begin
            norm_out = {sgn, 5'h1F, 10'h000};
        end else if ($signed(e_f) <= 7'sd0) begin
            norm_out = {sgn, 15'h0000};
        end else begin
            norm_out = {sgn, e_f[4:0], frac_sum[9:0]};
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= 16'h0000;
            dz    <= 1'b0;
            inv   <= 1'b0;
            a_r   <= 16'h0000;
            b_r   <= 16'h0000;
            rem_r <= '0;
            mb_r  <= '0;
            q_r   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r   <= A;
                        b_r   <= B;
                        busy  <= 1'b1;
                        state <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (spec) begin
                        out   <= sp_out;
                        dz    <= sp_dz;
                        inv   <= sp_inv;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        rem_r <= {1'b0, 1'b1, fa};
                        mb_r  <= {1'b1, fb};
                        q_r   <= '0;
                        cnt   <= '0;
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_r <= r_nx;
                    q_r   <= q_nx;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(DIV_CYCLES - 1)) begin
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    out   <= norm_out;
                    dz    <= 1'b0;
                    inv   <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
